// File: rtl/switch_pkt_mem_if.sv
// switch_pkt_mem_if: write, read and clear signals of the packet buffer, grouped per side.
interface switch_pkt_mem_if #(
    parameter int WIDTH = 128,
    parameter int AW    = 8
);
    localparam int BEW = WIDTH / 8;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [BEW-1:0]   wr_be;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             clr_req;
    logic             init_busy;
    logic             addr_err;
    modport master (
        output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, clr_req,
        input  rd_data, rd_valid, init_busy, addr_err
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, clr_req,
        output rd_data, rd_valid, init_busy, addr_err
    );
endinterface

// File: rtl/switch_pkt_mem.sv
// switch_pkt_mem: simple-dual-port packet buffer with byte enables, write-first forwarding,
// range checking and a DEPTH-cycle clear sweep after reset or on request.
module switch_pkt_mem #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input logic clk,
    input logic reset,
    switch_pkt_mem_if.slave bus
);
    localparam int BEW = WIDTH / 8;
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST    = (AW+1)'(DEPTH - 1);
    typedef enum logic {INIT, READY} state_t;
    state_t           state, state_nxt;
    logic [AW:0]      sweep_cnt, sweep_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             ready, wr_in, rd_in, wr_ok, rd_ok, collide;
    logic [AW-1:0]    wr_idx, rd_idx;
    logic [WIDTH-1:0] merged, rd_word, rd_data;
    logic             rd_valid, addr_err;
    assign ready   = state == READY;
    assign wr_in   = {1'b0, bus.wr_addr} < DEPTH_L;
    assign rd_in   = {1'b0, bus.rd_addr} < DEPTH_L;
    assign wr_ok   = ready && bus.wr_en && wr_in;
    assign rd_ok   = ready && bus.rd_en && rd_in;
    assign wr_idx  = wr_in ? bus.wr_addr : '0;
    assign rd_idx  = rd_in ? bus.rd_addr : '0;
    assign collide = wr_ok && rd_ok && bus.wr_addr == bus.rd_addr;
    // Post-write view of the addressed word, used to forward a colliding read.
    always_comb begin
        merged = mem[wr_idx];
        for (int i = 0; i < BEW; i++)
            merged[8*i +: 8] = bus.wr_be[i] ? bus.wr_data[8*i +: 8] : merged[8*i +: 8];
    end
    assign rd_word = !rd_in ? '0 : collide ? merged : mem[rd_idx];
    always_comb begin
        state_nxt = state == INIT ? (sweep_cnt == LAST ? READY : INIT) : (bus.clr_req ? INIT : READY);
        sweep_nxt = state == INIT ? sweep_cnt + 1'b1 : '0;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= INIT;
            sweep_cnt <= '0;
        end else begin
            state     <= state_nxt;
            sweep_cnt <= sweep_nxt;
        end
    end
    always_ff @(posedge clk) begin
        if (reset && !ready)
            mem[sweep_cnt[AW-1:0]] <= '0;
        else if (reset && wr_ok)
            for (int i = 0; i < BEW; i++)
                if (bus.wr_be[i]) mem[wr_idx][8*i +: 8] <= bus.wr_data[8*i +: 8];
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            rd_valid <= ready && bus.rd_en;
            addr_err <= ready && ((bus.wr_en && !wr_in) || (bus.rd_en && !rd_in));
            if (ready && bus.rd_en) rd_data <= rd_word;
        end
    end
    assign bus.rd_data   = rd_data;
    assign bus.rd_valid  = rd_valid;
    assign bus.addr_err  = addr_err;
    assign bus.init_busy = !ready;
endmodule

// File: tb/tb_switch_pkt_mem.sv
// tb_switch_pkt_mem: directed checks of a full-depth instance (256) and a partial-depth instance (200).
module tb_switch_pkt_mem;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   n, nb, bad;
    always #5 clk = ~clk;
    switch_pkt_mem_if #(.WIDTH(128), .AW(8)) a ();
    switch_pkt_mem_if #(.WIDTH(128), .AW(8)) b ();
    switch_pkt_mem #(.WIDTH(128), .DEPTH(256), .AW(8)) dut_a (.clk(clk), .reset(reset), .bus(a));
    switch_pkt_mem #(.WIDTH(128), .DEPTH(200), .AW(8)) dut_b (.clk(clk), .reset(reset), .bus(b));
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    initial begin
        reset = 1'b0;
        {a.wr_en, a.wr_addr, a.wr_data, a.wr_be, a.rd_en, a.rd_addr, a.clr_req} = '0;
        {b.wr_en, b.wr_addr, b.wr_data, b.wr_be, b.rd_en, b.rd_addr, b.clr_req} = '0;
        tick;
        tick;
        chk("rst_busy", a.init_busy, 1);
        chk("rst_valid", a.rd_valid, 0);
        chk("rst_data", a.rd_data, 0);
        chk("rst_err", a.addr_err, 0);
        reset = 1'b1;
        n = 0;
        nb = 0;
        while (a.init_busy && n < 1000) begin
            if (b.init_busy) nb++;
            tick;
            n++;
        end
        chk("init_len_256", n, 256);
        chk("init_len_200", nb, 200);
        a.rd_en = 1'b1;
        a.rd_addr = 8'd0;
        tick;
        chk("rd0_valid", a.rd_valid, 1);
        chk("rd0_data", a.rd_data, 0);
        a.rd_addr = 8'd255;
        tick;
        chk("rd255_valid", a.rd_valid, 1);
        chk("rd255_data", a.rd_data, 0);
        a.rd_en = 1'b0;
        tick;
        chk("idle_valid", a.rd_valid, 0);
        // byte-enable merge on address 5
        a.wr_en = 1'b1;
        a.wr_addr = 8'd5;
        a.wr_data = {16{8'h11}};
        a.wr_be = 16'hFFFF;
        tick;
        a.wr_data = {16{8'hAA}};
        a.wr_be = 16'h0001;
        tick;
        a.wr_data = {16{8'hFF}};
        a.wr_be = 16'h0000;
        tick;
        a.wr_en = 1'b0;
        a.rd_en = 1'b1;
        a.rd_addr = 8'd5;
        tick;
        chk("be_merge", a.rd_data, {{15{8'h11}}, 8'hAA});
        chk("be_err", a.addr_err, 0);
        a.rd_en = 1'b0;
        tick;
        chk("hold_valid", a.rd_valid, 0);
        chk("hold_data", a.rd_data, {{15{8'h11}}, 8'hAA});
        // write-first collisions
        a.wr_en = 1'b1;
        a.wr_addr = 8'd7;
        a.wr_data = {16{8'hFF}};
        a.wr_be = 16'h00FF;
        a.rd_en = 1'b1;
        a.rd_addr = 8'd7;
        tick;
        chk("coll7_data", a.rd_data, {64'h0, {64{1'b1}}});
        chk("coll7_valid", a.rd_valid, 1);
        a.wr_addr = 8'd5;
        a.wr_data = {16{8'h22}};
        a.wr_be = 16'h8000;
        a.rd_addr = 8'd5;
        tick;
        chk("coll5_data", a.rd_data, {8'h22, {14{8'h11}}, 8'hAA});
        a.wr_en = 1'b0;
        a.rd_addr = 8'd7;
        tick;
        chk("mem7_data", a.rd_data, {64'h0, {64{1'b1}}});
        a.rd_en = 1'b0;
        // out-of-range accesses on the 200-deep instance
        b.wr_en = 1'b1;
        b.wr_be = 16'hFFFF;
        b.wr_addr = 8'd199;
        b.wr_data = {16{8'h5A}};
        tick;
        chk("b199_err", b.addr_err, 0);
        b.wr_addr = 8'd210;
        b.wr_data = {16{8'hC3}};
        tick;
        chk("bwr210_err", b.addr_err, 1);
        chk("bwr210_valid", b.rd_valid, 0);
        b.wr_en = 1'b0;
        tick;
        chk("berr_pulse", b.addr_err, 0);
        b.rd_en = 1'b1;
        b.rd_addr = 8'd199;
        tick;
        chk("brd199_data", b.rd_data, {16{8'h5A}});
        chk("brd199_err", b.addr_err, 0);
        b.rd_addr = 8'd210;
        tick;
        chk("brd210_data", b.rd_data, 0);
        chk("brd210_valid", b.rd_valid, 1);
        chk("brd210_err", b.addr_err, 1);
        b.rd_addr = 8'd10;
        tick;
        chk("brd10_data", b.rd_data, 0);
        chk("brd10_err", b.addr_err, 0);
        b.rd_en = 1'b0;
        // clear sweep on request
        a.wr_en = 1'b1;
        a.wr_be = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            a.wr_addr = 8'(i);
            a.wr_data = {16{8'(i + 1)}};
            tick;
        end
        a.wr_en = 1'b0;
        a.clr_req = 1'b1;
        a.rd_en = 1'b1;
        a.rd_addr = 8'd1;
        tick;
        chk("clr_rd_data", a.rd_data, {16{8'h02}});
        chk("clr_rd_valid", a.rd_valid, 1);
        chk("clr_busy", a.init_busy, 1);
        a.clr_req = 1'b0;
        a.wr_en = 1'b1;
        a.wr_addr = 8'd3;
        a.wr_data = {16{8'h55}};
        n = 0;
        bad = 0;
        while (a.init_busy && n < 1000) begin
            tick;
            n++;
            if (a.rd_valid !== 1'b0) bad++;
        end
        a.wr_en = 1'b0;
        chk("clr_len", n, 256);
        chk("clr_rd_ignored", bad, 0);
        for (int i = 0; i < 4; i++) begin
            a.rd_addr = 8'(i);
            tick;
            chk("clr_zero", a.rd_data, 0);
        end
        a.rd_en = 1'b0;
        // reset in the middle of a sweep
        a.clr_req = 1'b1;
        tick;
        a.clr_req = 1'b0;
        repeat (100) tick;
        chk("mid_busy", a.init_busy, 1);
        reset = 1'b0;
        tick;
        reset = 1'b1;
        chk("mid_rst_busy", a.init_busy, 1);
        n = 0;
        while (a.init_busy && n < 1000) begin
            tick;
            n++;
        end
        chk("restart_len", n, 256);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
